// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//  - MD operation codes driven on the op port by the E stage.
//  - Default busy-cycle counts for multiply and divide.
//  - Helper that classifies an op as a multi-cycle MULT*/DIV* operation.
package mdu_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_multi(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// mdu_arith: combinational multiply/divide datapath.
//  i_op       in  3   MD op code (only MULT/MULTU/DIV/DIVU produce results)
//  i_rs       in  32  dividend / multiplicand
//  i_rt       in  32  divisor / multiplier
//  o_hi_res   out 32  product high word, or remainder
//  o_lo_res   out 32  product low word, or quotient
//  o_div_zero out 1   divide op with a zero divisor (result must not be committed)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MD_OP_W-1:0] i_op,
  input  logic [31:0]        i_rs,
  input  logic [31:0]        i_rt,
  output logic [31:0]        o_hi_res,
  output logic [31:0]        o_lo_res,
  output logic               o_div_zero
);

  logic        w_signed;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [63:0] w_rs_ext;
  logic [63:0] w_rt_ext;
  logic [63:0] w_prod;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  logic [31:0] w_rt_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_rs_neg = w_signed & i_rs[31];
  assign w_rt_neg = w_signed & i_rt[31];

  // Sign/zero extension makes one 64x64 multiply serve both MULT and MULTU.
  assign w_rs_ext = {{32{w_rs_neg}}, i_rs};
  assign w_rt_ext = {{32{w_rt_neg}}, i_rt};
  assign w_prod   = w_rs_ext * w_rt_ext;

  // Signed division on magnitudes: 0x80000000 has magnitude 2^31 as an
  // unsigned value, so MIN/-1 yields 0x80000000 with no overflow special case.
  assign w_rs_abs  = w_rs_neg ? (32'd0 - i_rs) : i_rs;
  assign w_rt_abs  = w_rt_neg ? (32'd0 - i_rt) : i_rt;
  // Divisor forced to 1 when zero so the divider never sees x/0.
  assign w_rt_safe = (i_rt == 32'd0) ? 32'd1 : w_rt_abs;
  assign w_q_mag   = w_rs_abs / w_rt_safe;
  assign w_r_mag   = w_rs_abs % w_rt_safe;

  always_comb begin
    o_hi_res   = 32'd0;
    o_lo_res   = 32'd0;
    o_div_zero = 1'b0;
    case (i_op)
      MD_MULT, MD_MULTU: begin
        o_hi_res = w_prod[63:32];
        o_lo_res = w_prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        o_div_zero = (i_rt == 32'd0);
        // Quotient truncates toward zero; remainder follows the dividend sign.
        o_lo_res   = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        o_hi_res   = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//  clk        in  1   clock, rising edge
//  reset      in  1   synchronous, active-high; aborts any operation in flight
//  start      in  1   E-stage MD instruction valid (single-cycle pulse)
//  op         in  3   MD op code (mdu_pkg)
//  rs_val     in  32  rs operand / MTHI-MTLO source
//  rt_val     in  32  rt operand
//  md_use_d   in  1   D-stage instruction touches HI/LO or the MD unit
//  busy       out 1   operation in progress
//  stall_req  out 1   hold the D-stage MD instruction
//  hi, lo     out 32  architectural HI/LO registers
// Handshake: an op is accepted on a rising edge where start=1 and busy=0;
// start while busy=1 is dropped with no state change. busy stays high for
// exactly N edges after acceptance and HI/LO update on the edge busy falls.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  input  logic               md_use_d,
  output logic               busy,
  output logic               stall_req,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi_tmp;
  logic [31:0]      r_lo_tmp;
  logic             r_div_zero;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [31:0]      w_hi_res;
  logic [31:0]      w_lo_res;
  logic             w_div_zero;
  logic             w_busy;

  mdu_arith u_arith (
    .i_op       (op),
    .i_rs       (rs_val),
    .i_rt       (rt_val),
    .o_hi_res   (w_hi_res),
    .o_lo_res   (w_lo_res),
    .o_div_zero (w_div_zero)
  );

  assign w_busy = (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_hi_tmp   <= 32'd0;
      r_lo_tmp   <= 32'd0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 1'b1;
      // Last busy edge: commit, unless the divisor was zero.
      if (r_cnt == CNT_W'(1) && !r_div_zero) begin
        r_hi <= r_hi_tmp;
        r_lo <= r_lo_tmp;
      end
    end else if (start) begin
      case (op)
        MD_MULT, MD_MULTU: begin
          r_cnt      <= MULT_N;
          r_hi_tmp   <= w_hi_res;
          r_lo_tmp   <= w_lo_res;
          r_div_zero <= 1'b0;
        end
        MD_DIV, MD_DIVU: begin
          r_cnt      <= DIV_N;
          r_hi_tmp   <= w_hi_res;
          r_lo_tmp   <= w_lo_res;
          r_div_zero <= w_div_zero;
        end
        MD_MTHI: r_hi <= rs_val;
        MD_MTLO: r_lo <= rs_val;
        default: ;
      endcase
    end
  end

  assign busy      = w_busy;
  // Includes the start cycle so a dependent MD op right behind never slips through.
  assign stall_req = md_use_d & (w_busy | (start & md_is_multi(op)));
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mdu_pkg::*;

  typedef longint unsigned u64_t;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference HI/LO state.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_use_d  (md_use_d),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted op, plain arithmetic.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint s_a, s_b, s_p;
    u64_t   u_p;
    s_a = longint'($signed(a));
    s_b = longint'($signed(b));
    case (o)
      3'd1: begin s_p = s_a * s_b; m_hi = s_p[63:32]; m_lo = s_p[31:0]; end
      3'd2: begin u_p = u64_t'(a) * u64_t'(b); m_hi = u_p[63:32]; m_lo = u_p[31:0]; end
      3'd3: if (b != 0) begin
        s_p = s_a / s_b; m_lo = s_p[31:0];
        s_p = s_a % s_b; m_hi = s_p[31:0];
      end
      3'd4: if (b != 0) begin
        u_p = u64_t'(a) / u64_t'(b); m_lo = u_p[31:0];
        u_p = u64_t'(a) % u64_t'(b); m_hi = u_p[31:0];
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MC;
    if (o == 3'd3 || o == 3'd4) return DC;
    return 0;
  endfunction

  // Driver: issue one op, count busy cycles, check the committed HI/LO.
  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    op     = MD_NONE;
    if (exp_cycles(o) > 0) begin
      chk({tag, "_nobypass_hi"}, {32'd0, hi}, {32'd0, old_hi});
      chk({tag, "_nobypass_lo"}, {32'd0, lo}, {32'd0, old_lo});
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles(o)));
    model_apply(o, a, b);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0]  r_o;
    logic [31:0] r_a, r_b;
    reset    = 1'b1;
    start    = 1'b0;
    op       = MD_NONE;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    md_use_d = 1'b0;
    repeat (3) tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {63'd0, stall_req}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    tick();

    // Directed cases
    do_op("mult_neg1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo_const", {32'd0, lo}, 64'hFFFF_FFFE);
    do_op("multu_max_x2", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", {32'd0, hi}, 64'h1);
    do_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
    do_op("divu_7_2", MD_DIVU, 32'd7, 32'd2);
    chk("divu_lo_const", {32'd0, lo}, 64'd3);
    chk("divu_hi_const", {32'd0, hi}, 64'd1);
    do_op("mthi", MD_MTHI, 32'h11, 32'd0);
    do_op("mtlo", MD_MTLO, 32'h22, 32'd0);
    do_op("div_by_zero", MD_DIV, 32'd5, 32'd0);
    chk("divzero_hi_const", {32'd0, hi}, 64'h11);
    chk("divzero_lo_const", {32'd0, lo}, 64'h22);
    do_op("divu_by_zero", MD_DIVU, 32'd9, 32'd0);
    do_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divmin_lo_const", {32'd0, lo}, 64'h8000_0000);
    chk("divmin_hi_const", {32'd0, hi}, 64'h0);
    do_op("nop0", MD_NONE, 32'h1234, 32'h5678);
    do_op("nop7", 3'd7, 32'h1234, 32'h5678);

    // Stall coverage, and a second start while busy that must be dropped
    md_use_d = 1'b1;
    start    = 1'b1;
    op       = MD_MTHI;
    rs_val   = m_hi;
    #1;
    chk("stall_mthi_start", {63'd0, stall_req}, 64'd0);
    op     = MD_MULT;
    rs_val = 32'd3;
    rt_val = 32'd4;
    #1;
    chk("stall_start_cycle", {63'd0, stall_req}, 64'd1);
    tick();
    start = 1'b0;
    op    = MD_NONE;
    chk("stall_busy1", {63'd0, stall_req}, 64'd1);
    start  = 1'b1;
    op     = MD_MULTU;
    rs_val = 32'd100;
    rt_val = 32'd100;
    tick();
    start = 1'b0;
    op    = MD_NONE;
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      chk("stall_busy_n", {63'd0, stall_req}, 64'd1);
      tick();
    end
    chk("stall_busy_cycles", 64'(n), 64'(MC));
    chk("stall_after_commit", {63'd0, stall_req}, 64'd0);
    model_apply(MD_MULT, 32'd3, 32'd4);
    chk("ignored_start_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("ignored_start_lo", {32'd0, lo}, {32'd0, m_lo});
    md_use_d = 1'b0;

    // Reset in the middle of a divide
    do_op("pre_mthi", MD_MTHI, 32'hABCD, 32'd0);
    start  = 1'b1;
    op     = MD_DIV;
    rs_val = 32'd100;
    rt_val = 32'd7;
    tick();
    start = 1'b0;
    op    = MD_NONE;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    repeat (DC + 2) tick();
    chk("abort_no_commit_hi", {32'd0, hi}, 64'd0);
    chk("abort_no_commit_lo", {32'd0, lo}, 64'd0);
    chk("abort_still_idle", {63'd0, busy}, 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      r_o = 3'($urandom_range(0, 7));
      r_a = rand_val();
      r_b = rand_val();
      do_op("rand", r_o, r_a, r_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
